// File: rtl/fwd_hazard_ctrl.sv
// Forwarding/hazard controller: tracks in-flight destinations per post-ID stage,
// registers per-operand forwarding selects and raises latency-based stall bubbles.
module fwd_match #(
  parameter int NSTAGES = 3,
  parameter int RW      = 5,
  parameter int SW      = 2
) (
  input  logic                            en_i,
  input  logic [RW-1:0]                   src_i,
  input  logic [NSTAGES-1:0]              tag_vld_i,
  input  logic [NSTAGES-1:0][RW-1:0]      tag_reg_i,
  input  logic [NSTAGES-1:0][SW-1:0]      tag_rdy_i,
  output logic [SW-1:0]                   sel_o,
  output logic                            haz_o
);
  // Scan oldest to youngest so the youngest producer's verdict is the one kept.
  always_comb begin
    sel_o = '0;
    haz_o = 1'b0;
    if (en_i) begin
      for (int j = NSTAGES-1; j >= 0; j--) begin
        if (tag_vld_i[j] && tag_reg_i[j] == src_i) begin
          if (SW'(j+1) >= tag_rdy_i[j]) begin
            sel_o = SW'(j+1);
            haz_o = 1'b0;
          end else begin
            sel_o = '0;
            haz_o = 1'b1;
          end
        end
      end
    end
  end
endmodule

module fwd_hazard_ctrl #(
  parameter  int NREGS      = 32,
  parameter  int NSTAGES    = 3,
  parameter  int NSRC       = 2,
  parameter  int ALU_READY  = 1,
  parameter  int LOAD_READY = 2,
  localparam int RW         = $clog2(NREGS),
  localparam int SW         = $clog2(NSTAGES+1)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ID_VALID,
  input  logic [NSRC*RW-1:0]   ID_SRC,
  input  logic [NSRC-1:0]      ID_SRC_USE,
  input  logic [RW-1:0]        ID_DST,
  input  logic                 ID_REGWRITE,
  input  logic                 ID_ISLOAD,
  input  logic                 HOLD,
  input  logic                 FLUSH,
  output logic [NSRC*SW-1:0]   FWD_SEL,
  output logic                 STALL,
  output logic [15:0]          STALL_COUNT
);
  // Entry [j] describes the instruction in stage j+1.
  logic [NSTAGES-1:0]          vld_pipe_q;
  logic [NSTAGES-1:0][RW-1:0]  reg_q;
  logic [NSTAGES-1:0][SW-1:0]  rdy_q;
  logic [NSRC-1:0][SW-1:0]     sel_q, sel_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic [NSRC-1:0]             haz_src;
  logic                        haz, ins, ent_vld_d;
  logic [SW-1:0]               ent_rdy_d;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    fwd_match #(.NSTAGES(NSTAGES), .RW(RW), .SW(SW)) u_match (
      .en_i      (ID_VALID & ID_SRC_USE[i] & (ID_SRC[i*RW +: RW] != '0)),
      .src_i     (ID_SRC[i*RW +: RW]),
      .tag_vld_i (vld_pipe_q),
      .tag_reg_i (reg_q),
      .tag_rdy_i (rdy_q),
      .sel_o     (sel_d[i]),
      .haz_o     (haz_src[i])
    );
  end

  assign haz       = (|haz_src) & ID_VALID & ~FLUSH;
  assign STALL     = HOLD | haz;
  assign ins       = ID_VALID & ~FLUSH & ~STALL;
  assign ent_vld_d = ins & ID_REGWRITE & (ID_DST != '0);
  assign ent_rdy_d = ID_ISLOAD ? SW'(LOAD_READY) : SW'(ALU_READY);
  assign cnt_d     = (haz && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      vld_pipe_q <= '0;
      reg_q      <= '0;
      rdy_q      <= '0;
      sel_q      <= '0;
      cnt_q      <= '0;
    end else if (!HOLD) begin
      for (int k = NSTAGES-1; k > 0; k--) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        reg_q[k]      <= reg_q[k-1];
        rdy_q[k]      <= rdy_q[k-1];
      end
      vld_pipe_q[0] <= ent_vld_d;
      reg_q[0]      <= ID_DST;
      rdy_q[0]      <= ent_rdy_d;
      sel_q         <= ins ? sel_d : '0;
      cnt_q         <= cnt_d;
    end
  end

  assign FWD_SEL     = sel_q;
  assign STALL_COUNT = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; a second instance with a long load
// latency keeps a hazard alive to drive the stall counter into saturation.
module tb_fwd_hazard_ctrl;
  logic        CLK, RESET;
  logic        id_valid, id_rw, id_ld, hold, flush;
  logic [9:0]  id_src;
  logic [1:0]  id_use;
  logic [4:0]  id_dst;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  logic        sat_en;
  logic [5:0]  sat_sel;
  logic        sat_stall;
  logic [15:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  fwd_hazard_ctrl u_dut (
    .CLK(CLK), .RESET(RESET), .ID_VALID(id_valid), .ID_SRC(id_src),
    .ID_SRC_USE(id_use), .ID_DST(id_dst), .ID_REGWRITE(id_rw),
    .ID_ISLOAD(id_ld), .HOLD(hold), .FLUSH(flush),
    .FWD_SEL(fwd_sel), .STALL(stall), .STALL_COUNT(stall_cnt)
  );

  // lw r5,0(r5) issued repeatedly: each copy stalls on the previous one for 6 cycles.
  fwd_hazard_ctrl #(.NSTAGES(7), .LOAD_READY(7)) u_sat (
    .CLK(CLK), .RESET(RESET), .ID_VALID(sat_en), .ID_SRC({5'd0, 5'd5}),
    .ID_SRC_USE(2'b01), .ID_DST(5'd5), .ID_REGWRITE(1'b1),
    .ID_ISLOAD(1'b1), .HOLD(1'b0), .FLUSH(1'b0),
    .FWD_SEL(sat_sel), .STALL(sat_stall), .STALL_COUNT(sat_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                        input logic [1:0] u, input logic [4:0] d,
                        input logic rw, input logic ld);
    id_valid = v; id_src = {s1, s0}; id_use = u; id_dst = d; id_rw = rw; id_ld = ld;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  initial begin
    RESET = 1'b0; hold = 1'b0; flush = 1'b0; sat_en = 1'b0;
    id_valid = 1'b0; id_src = '0; id_use = '0; id_dst = '0; id_rw = 1'b0; id_ld = 1'b0;

    // Reset state and STALL following HOLD during reset
    #12;
    chk("rst_fwd", fwd_sel, 4'h0);
    chk("rst_cnt", stall_cnt, 16'h0);
    chk("rst_stall", stall, 1'b0);
    hold = 1'b1; #1;
    chk("rst_stall_hold", stall, 1'b1);
    hold = 1'b0; #1;
    RESET = 1'b1;
    tick;

    // ALU back-to-back: add r3,r1,r2 ; sub r4,r3,r3
    set_id(1, 5'd2, 5'd1, 2'b11, 5'd3, 1, 0);
    chk("alu_a_stall", stall, 1'b0);
    tick;
    chk("alu_a_fwd", fwd_sel, 4'h0);
    set_id(1, 5'd3, 5'd3, 2'b11, 5'd4, 1, 0);
    chk("alu_b_stall", stall, 1'b0);
    tick;
    chk("alu_b_fwd", fwd_sel, 4'b0101);

    // Load-use: lw r5,0(r1) ; add r6,r5,r1
    set_id(1, 5'd0, 5'd1, 2'b01, 5'd5, 1, 1);
    chk("lw_stall", stall, 1'b0);
    tick;
    set_id(1, 5'd1, 5'd5, 2'b11, 5'd6, 1, 0);
    chk("lu_stall1", stall, 1'b1);
    tick;
    chk("lu_cnt1", stall_cnt, 16'd1);
    chk("lu_bubble_fwd", fwd_sel, 4'h0);
    chk("lu_stall2", stall, 1'b0);
    tick;
    chk("lu_fwd", fwd_sel, 4'b0010);
    chk("lu_cnt_after", stall_cnt, 16'd1);

    // Youngest producer wins; r0 never forwards
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 0); tick;
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd7, 1, 0); tick;
    set_id(1, 5'd0, 5'd7, 2'b11, 5'd0, 1, 0);
    chk("young_stall", stall, 1'b0);
    tick;
    chk("young_fwd", fwd_sel, 4'b0001);
    set_id(1, 5'd0, 5'd0, 2'b11, 5'd0, 0, 0); tick;
    chk("r0_fwd", fwd_sel, 4'h0);

    // Producer in the last stage forwards with sel=NSTAGES: lw r5,0(r7)
    set_id(1, 5'd0, 5'd7, 2'b01, 5'd5, 1, 1);
    chk("last_stall", stall, 1'b0);
    tick;
    chk("last_fwd", fwd_sel, 4'b0011);

    // HOLD for 3 cycles over a load-use hazard
    set_id(1, 5'd1, 5'd5, 2'b11, 5'd6, 1, 0);
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_stall", stall, 1'b1);
      tick;
      chk("hold_fwd", fwd_sel, 4'b0011);
      chk("hold_cnt", stall_cnt, 16'd1);
    end
    hold = 1'b0; #1;
    chk("unhold_stall", stall, 1'b1);
    tick;
    chk("unhold_cnt", stall_cnt, 16'd2);
    chk("unhold_fwd0", fwd_sel, 4'h0);
    chk("unhold_stall2", stall, 1'b0);
    tick;
    chk("unhold_fwd", fwd_sel, 4'b0010);
    chk("unhold_cnt2", stall_cnt, 16'd2);

    // FLUSH overrides a load-use hazard and inserts a bubble
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd5, 1, 1); tick;
    set_id(1, 5'd0, 5'd5, 2'b01, 5'd5, 1, 0);
    flush = 1'b1; #1;
    chk("flush_stall", stall, 1'b0);
    tick;
    flush = 1'b0;
    chk("flush_fwd", fwd_sel, 4'h0);
    chk("flush_cnt", stall_cnt, 16'd2);
    set_id(1, 5'd1, 5'd5, 2'b11, 5'd6, 1, 0);
    chk("flush_next_stall", stall, 1'b0);
    tick;
    chk("flush_bubble_fwd", fwd_sel, 4'b0010);

    // Asynchronous reset mid-stall with three valid tags
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd1, 1, 0); tick;
    set_id(1, 5'd0, 5'd0, 2'b00, 5'd2, 1, 0); tick;
    set_id(1, 5'd0, 5'd2, 2'b01, 5'd3, 1, 1); tick;
    set_id(1, 5'd2, 5'd3, 2'b11, 5'd4, 1, 0);
    chk("pre_rst_stall", stall, 1'b1);
    chk("pre_rst_fwd", fwd_sel, 4'b0001);
    chk("pre_rst_cnt", stall_cnt, 16'd2);
    #2 RESET = 1'b0; #1;
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_fwd", fwd_sel, 4'h0);
    chk("midrst_cnt", stall_cnt, 16'h0);
    #1 RESET = 1'b1; #1;
    chk("postrst_stall", stall, 1'b0);
    tick;
    chk("postrst_fwd", fwd_sel, 4'h0);
    chk("postrst_cnt", stall_cnt, 16'h0);

    // Saturating counter on the long-latency instance
    id_valid = 1'b0;
    sat_en = 1'b1;
    tick;
    chk("sat_first_stall", sat_stall, 1'b1);
    begin
      int n;
      n = 0;
      while (sat_cnt != 16'hFFFF && n < 80000) begin
        tick;
        n++;
      end
      chk("sat_reached", sat_cnt, 16'hFFFF);
    end
    for (int c = 0; c < 20; c++) tick;
    chk("sat_hold", sat_cnt, 16'hFFFF);
    sat_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the pipelined MIPS core, the successor to the fixed two-operand EXE/MEM/WB forwarding unit. It keeps an internal tag pipeline of in-flight destination registers, one entry per post-ID stage. It generates registered per-operand forwarding selects, inserts load-use (and generally latency-based) stall bubbles, honours downstream freezes and ID squashes, and keeps a saturating stall counter. It sits beside ID: it consumes the instruction decoded in ID and drives `WANT_FREEZE` toward IF/ID and the operand muxes in EXE.

## Interface

Parameters:
- `NREGS`, 32: architectural registers; `RW = $clog2(NREGS)`.
- `NSTAGES`, 3: tracked stages after ID (1 = EXE … `NSTAGES` = WB); `SW = $clog2(NSTAGES+1)`.
- `NSRC`, 2: source operands per instruction.
- `ALU_READY`, 1: first stage whose output latch holds an ALU result.
- `LOAD_READY`, 2: first stage whose output latch holds load data.

Ports:
- `CLK` in 1: the single clock, rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `ID_VALID` in 1: ID holds a real instruction.
- `ID_SRC` in NSRC*RW: source register numbers; operand i is at `[i*RW +: RW]`.
- `ID_SRC_USE` in NSRC: operand i is actually read.
- `ID_DST` in RW: destination register.
- `ID_REGWRITE` in 1: the instruction writes `ID_DST`.
- `ID_ISLOAD` in 1: the result is ready at `LOAD_READY`, otherwise at `ALU_READY`.
- `HOLD` in 1: downstream freeze (data memory not valid).
- `FLUSH` in 1: squash the ID instruction.
- `FWD_SEL` out NSRC*SW: registered; 0 = register-file value, k = output latch of stage k.
- `STALL` out 1: combinational; freeze IF/ID this cycle.
- `STALL_COUNT` out 16: number of hazard stall cycles, saturating.

## Operation

Tag pipeline:
- `tag[1..NSTAGES]` each holds {valid, reg, ready}.
- `tag[k]` is the instruction currently in stage k.

Insertion (`ins`):
- `ins = ID_VALID & ~FLUSH & ~STALL`.
- The inserted entry is {`ID_REGWRITE & ID_DST!=0`, `ID_DST`, `ID_ISLOAD ? LOAD_READY : ALU_READY`}.

Match, per operand i, evaluated when `ID_VALID & ID_SRC_USE[i] & ID_SRC[i]!=0`:
- Find the smallest k (youngest producer) with a valid `tag[k]` whose reg equals `ID_SRC[i]`.
- No match: sel_i = 0.
- Match with k ≥ `tag[k].ready`: sel_i = k.
- Match with k < `tag[k].ready`: operand i has a hazard.

Stall:
- `haz` = OR over operands of the per-operand hazards, gated with `ID_VALID & ~FLUSH`.
- `STALL = HOLD | haz`.

Each rising edge:
- HOLD=1: the tag pipeline, `FWD_SEL` and `STALL_COUNT` all hold.
- HOLD=0: `tag[k+1] <= tag[k]` and the entry leaving `tag[NSTAGES]` is dropped. Then:
  - `tag[1]` <= the inserted entry if `ins`, else a bubble (valid=0).
  - `FWD_SEL` <= the sel vector if `ins`, else 0.
  - `STALL_COUNT` increments if `haz`, saturating at 0xFFFF.

Rules:
- Register 0 never creates a valid entry and never matches.
- FLUSH overrides any hazard: no stall is raised and a bubble is inserted.
- HOLD and `haz` together: `STALL=1`, but `STALL_COUNT` does not increment.
- An instruction whose `ID_REGWRITE=0` still advances, as an invalid entry.

## Timing

- Reset (`RESET`=0, asynchronous): every tag invalid, `FWD_SEL`=0, `STALL_COUNT`=0, so `STALL`=`HOLD`.
- `FWD_SEL` is computed while the consumer is in ID and is valid during the consumer's EXE cycle, one edge later.
- An ALU producer immediately followed by its consumer gets sel=1, with zero stall.
- A load producer immediately followed by its consumer (default parameters):
  - 1 stall cycle.
  - The consumer then issues with sel=2.
- A producer in `tag[NSTAGES]` while the consumer is in ID forwards with sel=`NSTAGES`.
- The entry leaves on the next edge; its register-file write completes on that same edge.
- Stall latency is combinational, the same cycle the hazard is present.
- Reset asserted mid-stall:
  - The stall clears immediately (`STALL=HOLD`).
  - Tags are dropped; no residual bubble is inserted.

## Test plan

- Reset mid-run with 3 valid tags and `STALL_COUNT`=5 → all outputs go to 0 asynchronously; after release, `STALL`=0 for any ID operand.
- ALU back-to-back: `add r3` then `sub r4,r3,r3` → `STALL`=0; next cycle `FWD_SEL`={1,1}.
- Load-use: `lw r5` then `add r6,r5,r1`:
  - `STALL`=1 for exactly 1 cycle and `STALL_COUNT`=1.
  - Then `FWD_SEL[0]`=2, `FWD_SEL[1]`=0.
- Youngest wins: r7 is written by the instructions in both `tag[1]` and `tag[2]`; ID reads r7 → sel=1. A write to r0 followed by a read of r0 → sel=0.
- HOLD for 3 cycles during a load-use hazard:
  - `STALL`=1 throughout.
  - Tags, `FWD_SEL` and `STALL_COUNT` are unchanged.
  - After HOLD drops, exactly 1 counted stall remains.
- FLUSH with a load-use hazard present → `STALL`=0 and a bubble enters `tag[1]`. Separately, force 65536 hazard cycles → `STALL_COUNT` stays at 0xFFFF.
